// File: rtl/cfa_rgb_streamer.sv
// Reads the green/red/blue planes row-major and streams one RGB beat per pixel
// with sof/eol/eof tags; a 2-entry fall-through FIFO absorbs read latency and back-pressure.
module cfa_rgb_streamer #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int DIM_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  rowMax,
    input  logic [DIM_W-1:0]  colMax,
    output logic              readEnable,
    output logic [ADDR_W-1:0] readAddress,
    input  logic [DATA_W-1:0] greenRead,
    input  logic [DATA_W-1:0] redRead,
    input  logic [DATA_W-1:0] blueRead,
    output logic              pixValid,
    input  logic              pixReady,
    output logic [DATA_W-1:0] pixRed,
    output logic [DATA_W-1:0] pixGreen,
    output logic [DATA_W-1:0] pixBlue,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    localparam int BEAT_W = 3 * DATA_W + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]  row_max_q, col_max_q, row, col;
    logic [ADDR_W-1:0] addr;
    logic              in_flight;
    logic [2:0]        tag_q;
    logic [BEAT_W-1:0] fifo_mem [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        fifo_count;
    logic [BEAT_W-1:0] head;
    logic [2:0]        occ;
    logic              accept, zero_dim, issue, pop, push;
    logic              last_col, last_row, head_eof, eof_pop;

    // Stream handshake: a beat transfers on a rising edge where pixValid & pixReady;
    // pixValid never drops and the head never changes until that transfer happens.
    assign pixValid = (fifo_count != 2'd0);
    assign pop      = pixValid & pixReady;
    assign push     = in_flight;
    assign head     = fifo_mem[rd_ptr];
    assign head_eof = head[BEAT_W-3];
    assign eof_pop  = pop & head_eof;

    assign accept   = start & (state == S_IDLE);
    assign zero_dim = (rowMax == '0) | (colMax == '0);
    assign last_col = (col == col_max_q - 1'b1);
    assign last_row = (row == row_max_q - 1'b1);

    // FIFO occupancy plus the read still in the memory pipe must stay within 2 entries.
    assign occ   = {1'b0, fifo_count} + {2'b00, in_flight};
    assign issue = (state == S_FETCH) & (occ < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = zero_dim ? S_DONE : S_FETCH;
            S_FETCH: if (issue && last_col && last_row) state_nxt = S_DRAIN;
            S_DRAIN: if (eof_pop) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        readEnable = issue;
        fsm_state  = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_max_q   <= '0;
            col_max_q   <= '0;
            row         <= '0;
            col         <= '0;
            addr        <= '0;
            in_flight   <= 1'b0;
            tag_q       <= 3'b000;
        end else begin
            in_flight <= issue;
            if (accept && !zero_dim) begin
                row_max_q <= rowMax;
                col_max_q <= colMax;
                row       <= '0;
                col       <= '0;
                addr      <= '0;
            end else if (issue) begin
                tag_q <= {(row == '0) && (col == '0), last_col, last_col && last_row};
                addr  <= addr + 1'b1;
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign readAddress = addr;

    // A zero-sized frame still raises busy for its single DONE cycle, so done follows one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= ((state == S_DRAIN) && eof_pop) || ((state == S_DONE) && busy);
            if (accept)
                busy <= 1'b1;
            else if ((state == S_DONE) || ((state == S_DRAIN) && eof_pop))
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_q, redRead, greenRead, blueRead};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pixRed   = head[3*DATA_W-1:2*DATA_W];
    assign pixGreen = head[2*DATA_W-1:DATA_W];
    assign pixBlue  = head[DATA_W-1:0];
    assign sof      = pixValid & head[BEAT_W-1];
    assign eol      = pixValid & head[BEAT_W-2];
    assign eof      = pixValid & head_eof;

endmodule

// File: tb/tb_cfa_rgb_streamer.sv
// Scoreboard bench for cfa_rgb_streamer: a plane-memory model feeds reads, expected
// beats are queued per frame and a negedge monitor compares every accepted beat.
module tb_cfa_rgb_streamer;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int DIM_W  = 11;
  localparam int BW     = 3 * DATA_W + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  rowMax, colMax;
  logic              readEnable;
  logic [ADDR_W-1:0] readAddress;
  logic [DATA_W-1:0] greenRead = '0, redRead = '0, blueRead = '0;
  logic              pixValid, pixReady;
  logic [DATA_W-1:0] pixRed, pixGreen, pixBlue;
  logic              sof, eol, eof, busy, done;
  logic [1:0]        fsm_state;

  cfa_rgb_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rowMax(rowMax), .colMax(colMax),
    .readEnable(readEnable), .readAddress(readAddress),
    .greenRead(greenRead), .redRead(redRead), .blueRead(blueRead),
    .pixValid(pixValid), .pixReady(pixReady),
    .pixRed(pixRed), .pixGreen(pixGreen), .pixBlue(pixBlue),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- plane memory model ----------------
  function automatic logic [DATA_W-1:0] g_val(input int a);
    return DATA_W'(a);
  endfunction
  function automatic logic [DATA_W-1:0] r_val(input int a);
    return DATA_W'(a + 'h100);
  endfunction
  function automatic logic [DATA_W-1:0] b_val(input int a);
    return DATA_W'(a + 'h200);
  endfunction

  always @(posedge clk) begin
    if (readEnable) begin
      greenRead <= g_val(int'(readAddress));
      redRead   <= r_val(int'(readAddress));
      blueRead  <= b_val(int'(readAddress));
    end
  end

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0, n_errors = 0;
  int base = 0, exp_addr = 0, issued = 0, popped = 0, beats = 0;
  int sof_n = 0, eol_n = 0, eof_n = 0, done_n = 0, busy_n = 0;
  int first_re = -1, first_valid = -1, done_off = -1, last_addr = -1;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  bit hold_prev = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int rm, input int cm);
    for (int r = 0; r < rm; r++) begin
      for (int c = 0; c < cm; c++) begin
        int a;
        logic fs, fl, fe;
        a  = r * cm + c;
        fs = (r == 0) && (c == 0);
        fl = (c == cm - 1);
        fe = fl && (r == rm - 1);
        exp_q.push_back({fs, fl, fe, r_val(a), g_val(a), b_val(a)});
      end
    end
  endtask

  task automatic clear_stats();
    exp_addr = 0; issued = 0; popped = 0; beats = 0;
    sof_n = 0; eol_n = 0; eof_n = 0; done_n = 0; busy_n = 0;
    first_re = -1; first_valid = -1; done_off = -1; last_addr = -1;
    hold_prev = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int rm, input int cm);
    clear_stats();
    @(posedge clk);
    #1;
    rowMax = DIM_W'(rm);
    colMax = DIM_W'(cm);
    start  = 1'b1;
    @(posedge clk);
    #1;
    base  = cyc;
    start = 1'b0;
  endtask

  task automatic pulse_start_only(input int rm, input int cm);
    @(posedge clk);
    #1;
    rowMax = DIM_W'(rm);
    colMax = DIM_W'(cm);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input string name);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_n == 0) check({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (beats < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (beats < target) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    pixReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) pixReady = 1'b1;
      else               pixReady = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && mon_en) begin
      logic [BW-1:0] beat;
      int pop_now;
      beat    = {sof, eol, eof, pixRed, pixGreen, pixBlue};
      pop_now = (pixValid && pixReady) ? 1 : 0;
      if (readEnable) begin
        check("read_addr", readAddress, exp_addr);
        check("outstanding_le_2", ((issued - popped - pop_now) < 2), 1);
        if (first_re < 0) first_re = cyc - base + 1;
        last_addr = int'(readAddress);
        exp_addr++;
        issued++;
      end
      if (hold_prev) check("held_beat_stable", {pixValid, beat}, {1'b1, prev_beat});
      if (pop_now == 1) begin
        if (exp_q.size() == 0) check("unexpected_beat", {1'b1, beat}, 0);
        else                   check("beat", beat, exp_q.pop_front());
        if (first_valid < 0) first_valid = cyc - base + 1;
        beats++;
        popped++;
        sof_n += int'(sof);
        eol_n += int'(eol);
        eof_n += int'(eof);
      end
      hold_prev = pixValid && !pixReady;
      prev_beat = beat;
      if (done) begin
        done_n++;
        done_off = cyc - base + 1;
      end
      if (busy) busy_n++;
    end
  end

  function automatic logic [63:0] out_vec();
    return {2'b00, readEnable, readAddress, pixValid, pixRed, pixGreen, pixBlue,
            sof, eol, eof, busy, done, fsm_state};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; start = 1'b0; rowMax = '0; colMax = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // 3x4 frame, always ready: exact latency and tag positions
    rdy_mode = 0;
    push_frame(3, 4);
    start_frame(3, 4);
    wait_frame(200, "t1");
    check("t1_first_read_cycle", first_re, 1);
    check("t1_first_valid_cycle", first_valid, 3);
    check("t1_done_cycle", done_off, 15);
    check("t1_beats", beats, 12);
    check("t1_sof_n", sof_n, 1);
    check("t1_eol_n", eol_n, 3);
    check("t1_eof_n", eof_n, 1);
    check("t1_done_n", done_n, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // same frame under random back-pressure
    rdy_mode = 1;
    push_frame(3, 4);
    start_frame(3, 4);
    wait_frame(400, "t2");
    check("t2_beats", beats, 12);
    check("t2_eol_n", eol_n, 3);
    check("t2_queue_empty", exp_q.size(), 0);
    rdy_mode = 0;

    // 1x1 frame: all three tags on the single beat
    push_frame(1, 1);
    start_frame(1, 1);
    wait_frame(50, "t3");
    check("t3_beats", beats, 1);
    check("t3_tags", {sof_n[3:0], eol_n[3:0], eof_n[3:0]}, 12'h111);
    check("t3_done_n", done_n, 1);

    // zero rows: no reads, no beats, one busy cycle, done two cycles after start
    start_frame(0, 5);
    wait_frame(50, "t4");
    check("t4_beats", beats, 0);
    check("t4_reads", issued, 0);
    check("t4_busy_cycles", busy_n, 1);
    check("t4_done_cycle", done_off, 2);

    // 4x1 frame: eol on every beat
    push_frame(4, 1);
    start_frame(4, 1);
    wait_frame(100, "t5");
    check("t5_beats", beats, 4);
    check("t5_eol_n", eol_n, 4);

    // start with other dimensions mid-frame is ignored
    push_frame(3, 4);
    start_frame(3, 4);
    wait_beats(3, 100, "t6_wait");
    pulse_start_only(5, 4);
    wait_frame(200, "t6");
    check("t6_beats", beats, 12);
    check("t6_reads", issued, 12);
    check("t6_queue_empty", exp_q.size(), 0);

    // asynchronous reset mid 70x70 frame
    push_frame(70, 70);
    start_frame(70, 70);
    wait_beats(6, 200, "t7_wait");
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t7_async_clear", out_vec(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t7_held_in_reset", out_vec(), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    clear_stats();
    repeat (4) @(negedge clk);
    check("t7_idle_after_reset", {done_n[3:0], issued[3:0], 1'b0, fsm_state}, 0);

    // full 70x70 frame with 50% random ready
    rdy_mode = 2;
    push_frame(70, 70);
    start_frame(70, 70);
    wait_frame(40000, "t8");
    check("t8_beats", beats, 4900);
    check("t8_sof_n", sof_n, 1);
    check("t8_eol_n", eol_n, 70);
    check("t8_eof_n", eof_n, 1);
    check("t8_last_addr", last_addr, 4899);
    check("t8_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
